ingress_wrreq_proc: RTL

//  Downstream consumer of the ingress parse stage's memory-write request channel (wrreq_*).
//  - Takes 128b payload beats plus the TLP header meta (tlp_head_t).
//  - Serialises each MWr TLP into single-DW local write commands: 64b address, 32b data, 4b byte enable.
//  - Feeds the BAR/register write port; back-pressure propagates to the parse stage through wrreq_rdy.

---
 rtl/ingress_wrreq_proc.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/ingress_wrreq_proc.sv
// ingress_wrreq_proc: serialises MWr TLP payload beats into single-DW local write commands.
// Optional malformed byte-enable check with DROP path: define WRREQ_ERR_CHK_EN.

`ifndef PCIE_DATA_WIDTH
`define PCIE_DATA_WIDTH 128
`endif
`ifndef PCIE_DATA_KW
`define PCIE_DATA_KW 16
`endif

package ingress_wrreq_pkg;
  typedef logic [127:0] tlp_head_t;
endpackage

module ingress_wrreq_proc
  import ingress_wrreq_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int MAX_LEN_DW = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [`PCIE_DATA_WIDTH-1:0] wrreq_data,
  input  logic [`PCIE_DATA_KW-1:0]    wrreq_keep,
  input  tlp_head_t                   wrreq_meta,
  input  logic                        wrreq_valid,
  output logic                        wrreq_rdy,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [31:0]                 wr_data,
  output logic [3:0]                  wr_be,
  output logic                        wr_valid,
  input  logic                        wr_rdy,
  output logic                        err_malformed
);

  localparam int NDW   = `PCIE_DATA_WIDTH / 32;
  localparam int PTR_W = (NDW > 1) ? $clog2(NDW) : 1;
  localparam int CNT_W = $clog2(NDW + 1);
  localparam int REM_W = $clog2(MAX_LEN_DW + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [REM_W-1:0]            rem_q, rem_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [3:0]                  fbe_q, fbe_d;
  logic [3:0]                  lbe_q, lbe_d;
  logic                        first_q, first_d;
  logic [`PCIE_DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [CNT_W-1:0]            hold_cnt_q, hold_cnt_d;
  logic [PTR_W-1:0]            ptr_q, ptr_d;
  logic                        hold_vld_q, hold_vld_d;
  logic                        wr_valid_q, wr_valid_d;
  logic [31:0]                 wr_data_q, wr_data_d;
  logic [3:0]                  wr_be_q, wr_be_d;

  logic             fire;
  logic             hold_done;
  logic             accept;
  logic [CNT_W-1:0] beat_cnt;
  logic [9:0]       hdr_len;
  logic [REM_W-1:0] hdr_rem;
  logic [63:0]      hdr_a;
  logic [3:0]       hdr_fbe;
  logic [3:0]       hdr_lbe;
  logic             unused_bits;

  function automatic logic [REM_W-1:0] sat_sub(input logic [REM_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a > REM_W'(b)) ? a - REM_W'(b) : '0;
  endfunction

  assign hdr_len = wrreq_meta[9:0];
  assign hdr_fbe = wrreq_meta[35:32];
  assign hdr_lbe = wrreq_meta[39:36];
  assign hdr_a   = {wrreq_meta[95:64], wrreq_meta[127:96]};
  assign hdr_rem = (hdr_len == 10'd0) ? REM_W'(MAX_LEN_DW) : REM_W'(hdr_len);

  assign unused_bits = ^{wrreq_meta[63:40], wrreq_meta[31:10], wrreq_keep, hdr_a};

  always_comb begin
    beat_cnt = '0;
    for (int i = 0; i < NDW; i++) begin
      beat_cnt = beat_cnt + CNT_W'(wrreq_keep[4*i]);
    end
  end

  // The last TLP DW flushes the hold even if the beat carried excess DWs.
  assign fire      = wr_valid_q & wr_rdy;
  assign hold_done = fire & (((CNT_W'(ptr_q) + CNT_W'(1)) == hold_cnt_q) |
                             (rem_q == REM_W'(1)));
  assign wrreq_rdy = ~rst & (~hold_vld_q | hold_done);
  assign accept    = wrreq_valid & wrreq_rdy;

`ifdef WRREQ_ERR_CHK_EN
  logic hdr_malformed;
  logic err_d, err_q;
  assign hdr_malformed = (hdr_len == 10'd1) ? (hdr_lbe != 4'h0)
                                            : ((hdr_lbe == 4'h0) | (hdr_fbe == 4'h0));
`endif

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    addr_d      = addr_q;
    fbe_d       = fbe_q;
    lbe_d       = lbe_q;
    first_d     = first_q;
    hold_data_d = hold_data_q;
    hold_cnt_d  = hold_cnt_q;
    ptr_d       = ptr_q;
    hold_vld_d  = hold_vld_q;
`ifdef WRREQ_ERR_CHK_EN
    err_d       = 1'b0;
`endif

    if (fire) begin
      rem_d   = rem_q - REM_W'(1);
      addr_d  = addr_q + ADDR_W'(4);
      ptr_d   = ptr_q + PTR_W'(1);
      first_d = 1'b0;
      if (hold_done) hold_vld_d = 1'b0;
      if (rem_q == REM_W'(1)) state_d = ST_IDLE;
    end

    // state_d already reflects a TLP ending this cycle, so a same-cycle beat becomes a header.
    if (accept) begin
      if (state_d == ST_IDLE) begin
        rem_d   = hdr_rem;
        addr_d  = {hdr_a[ADDR_W-1:2], 2'b00};
        fbe_d   = hdr_fbe;
        lbe_d   = hdr_lbe;
        first_d = 1'b1;
        state_d = ST_WR;
`ifdef WRREQ_ERR_CHK_EN
        if (hdr_malformed) begin
          err_d   = 1'b1;
          first_d = 1'b0;
          rem_d   = sat_sub(hdr_rem, beat_cnt);
          state_d = (sat_sub(hdr_rem, beat_cnt) == '0) ? ST_IDLE : ST_DROP;
        end
`endif
      end else if (state_d == ST_DROP) begin
        rem_d = sat_sub(rem_q, beat_cnt);
        if (sat_sub(rem_q, beat_cnt) == '0) state_d = ST_IDLE;
      end

      if (state_d == ST_WR) begin
        hold_data_d = wrreq_data;
        hold_cnt_d  = beat_cnt;
        ptr_d       = '0;
        hold_vld_d  = (beat_cnt != '0);
      end
    end

    wr_valid_d = (state_d == ST_WR) & hold_vld_d;
    wr_data_d  = hold_data_d[31:0];
    for (int i = 0; i < NDW; i++) begin
      if (ptr_d == PTR_W'(i)) wr_data_d = hold_data_d[32*i +: 32];
    end
    wr_be_d = first_d ? fbe_d : ((rem_d == REM_W'(1)) ? lbe_d : 4'hF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      addr_q      <= '0;
      fbe_q       <= '0;
      lbe_q       <= '0;
      first_q     <= 1'b0;
      hold_data_q <= '0;
      hold_cnt_q  <= '0;
      ptr_q       <= '0;
      hold_vld_q  <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_data_q   <= '0;
      wr_be_q     <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      addr_q      <= addr_d;
      fbe_q       <= fbe_d;
      lbe_q       <= lbe_d;
      first_q     <= first_d;
      hold_data_q <= hold_data_d;
      hold_cnt_q  <= hold_cnt_d;
      ptr_q       <= ptr_d;
      hold_vld_q  <= hold_vld_d;
      wr_valid_q  <= wr_valid_d;
      wr_data_q   <= wr_data_d;
      wr_be_q     <= wr_be_d;
    end
  end

`ifdef WRREQ_ERR_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign err_malformed = err_q;
`else
  assign err_malformed = 1'b0;
`endif

  assign wr_valid = wr_valid_q;
  assign wr_addr  = addr_q;
  assign wr_data  = wr_data_q;
  assign wr_be    = wr_be_q;

endmodule
